pass_lock_fsm: RTL and testbench
================================

Name: pass_lock_fsm

Overview:
- Parametrised successor of the lab-10 password-gated enable controller.
- Requester raises rqst, then submits a code on confirm. A correct code grants access. In SAVE, data is latched and one of NCH channel enables is driven.
- Adds a programmable password, a retry budget, a timed lockout trap and N-channel steering; sits between the keypad/switch front-end and the downstream channel loads.

Parameters:
- DW, 4, width of pass_data/dout/stored password.
- RST_PASS, {DW{1'b1}}, password value loaded on reset.
- MAX_TRIES, 3, wrong codes allowed before TRAP (>=1).
- LOCK_CYCLES, 16, TRAP duration in clk cycles (>=2).
- NCH, 2, number of channel enables; power of two, 2..2**DW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rqst  in  1  access request level; 0 aborts (except in TRAP).
- confirm  in  1  submit strobe; only its rising edge is used.
- pass_data  in  DW  code / data / channel select.
- pass_wr  in  1  in SAVE: program pass_data as the new password.
- en  out  NCH  one-hot channel enable (replaces en_left/en_right).
- dout  out  DW  latched data.
- state  out  3  current state encoding.
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts.
- locked  out  1  high while in TRAP.

Behaviour:
- Reset (rst=0, async): state=IDLE, en=0, dout=0, pass_reg=RST_PASS, fail_cnt=0, lock_cnt=0, confirm_q=0, locked=0, tries_left=MAX_TRIES.
- All outputs are registered; effects appear the cycle after the sampling edge.
- cedge = confirm & ~confirm_q. confirm_q updates every cycle. A held confirm counts once.
- State encodings: IDLE=000, ACTIVE=001, GRANT=101, TRAP=111, SAVE=110.
- IDLE:
  - rqst=1 -> ACTIVE; en<=0.
- ACTIVE:
  - rqst=0 -> IDLE; en<=0. rqst=0 has priority over cedge in the same cycle.
  - cedge with pass_data==pass_reg -> GRANT; fail_cnt<=0.
  - cedge with mismatch and fail_cnt+1<MAX_TRIES -> stay ACTIVE; fail_cnt++.
  - cedge with mismatch and fail_cnt+1==MAX_TRIES -> TRAP; lock_cnt<=LOCK_CYCLES-1; fail_cnt<=MAX_TRIES.
- GRANT:
  - rqst=0 -> IDLE.
  - cedge -> SAVE.
- SAVE, each cycle with rqst=1:
  - dout<=pass_data.
  - en<=one-hot at index pass_data[$clog2(NCH)-1:0].
  - If pass_wr=1, pass_reg<=pass_data in the same cycle.
  - rqst=0 -> IDLE; en<=0; dout holds its last value.
- TRAP:
  - rqst is ignored.
  - lock_cnt decrements each cycle.
  - At lock_cnt==0 -> IDLE; fail_cnt<=0.
  - Dwell is exactly LOCK_CYCLES cycles.
- fail_cnt is cleared only by a correct code, TRAP expiry or reset. It is not cleared by rqst=0, so toggling rqst does not refill tries.
- tries_left = MAX_TRIES - fail_cnt. locked = (state==TRAP).
- pass_wr is ignored outside SAVE.
- Reset mid-operation returns to the reset values, including the programmed password and lockout.

Decomposition:
- Shared package pass_lock_pkg holds the state localparams (IDLE/ACTIVE/GRANT/TRAP/SAVE, 3-bit) for use by testbench and top.
- One sub-module, edge_det: registered rising-edge detector for confirm.
- The down-counter stays inline.

Test Plan (defaults DW=4, MAX_TRIES=3, LOCK_CYCLES=16, NCH=2):
- Reset, rqst=1, confirm edge with 4'hF -> ACTIVE then GRANT (101). Confirm edge again -> SAVE. pass_data=4'h6 -> dout=6, en=2'b01. pass_data=4'h3 -> en=2'b10.
- In ACTIVE, submit 4'h2 three times -> tries_left 3,2,1, then TRAP (111) with locked=1. Hold confirm high for 5 cycles -> only one attempt counted.
- In TRAP, drop rqst -> state stays 111 for exactly 16 cycles, then IDLE with tries_left=3.
- Two wrong codes, drop rqst to IDLE, re-request -> tries_left=1. A third wrong code -> TRAP.
- In SAVE, pass_data=4'h9 with pass_wr=1, exit, re-request -> 4'hF now fails and 4'h9 grants.
- Assert rst low mid-TRAP and again mid-SAVE after a reprogram -> immediate IDLE, en=0, dout=0, and 4'hF grants again.

Source files
------------

// File: rtl/pass_lock_pkg.sv
// Shared state encodings for the password-gated channel enable controller.
// The top-level design and the testbench both use these encodings.
package pass_lock_pkg;

   localparam logic [2:0] IDLE   = 3'b000;
   localparam logic [2:0] ACTIVE = 3'b001;
   localparam logic [2:0] GRANT  = 3'b101;
   localparam logic [2:0] TRAP   = 3'b111;
   localparam logic [2:0] SAVE   = 3'b110;

endpackage

// File: rtl/pass_lock_fsm_edge_det.sv
// Registered rising-edge detector.
// A level that stays high yields a single-cycle pulse on its first cycle.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic din_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) din_q <= 1'b0;
      else      din_q <= din;
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/pass_lock_fsm.sv
// Password-gated N-channel enable controller.
// Provides a programmable code, a retry budget, a timed lockout and one-hot channel steering.
module pass_lock_fsm
   import pass_lock_pkg::*;
#(
   parameter int             DW          = 4,
   parameter logic [DW-1:0]  RST_PASS    = {DW{1'b1}},
   parameter int             MAX_TRIES   = 3,
   parameter int             LOCK_CYCLES = 16,
   parameter int             NCH         = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rqst,
   input  logic                           confirm,
   input  logic [DW-1:0]                  pass_data,
   input  logic                           pass_wr,
   output logic [NCH-1:0]                 en,
   output logic [DW-1:0]                  dout,
   output logic [2:0]                     state,
   output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
   output logic                           locked
);

   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam int LW = $clog2(LOCK_CYCLES);
   localparam int SW = $clog2(NCH);

   localparam logic [NCH-1:0] EN_ONE = {{(NCH-1){1'b0}}, 1'b1};

   logic [2:0]     state_q, state_d;
   logic [NCH-1:0] en_q, en_d;
   logic [DW-1:0]  dout_q, dout_d;
   logic [DW-1:0]  pass_q, pass_d;
   logic [TW-1:0]  fail_cnt_q, fail_cnt_d;
   logic [LW-1:0]  lock_cnt_q, lock_cnt_d;

   logic           cedge;
   logic           code_ok;
   logic [TW:0]    fail_inc;
   logic           budget_left;

   edge_det u_edge_det (
      .clk  (clk),
      .rst  (rst),
      .din  (confirm),
      .rise (cedge)
   );

   assign code_ok     = (pass_data == pass_q);
   assign fail_inc    = {1'b0, fail_cnt_q} + (TW+1)'(1);
   assign budget_left = (fail_inc < (TW+1)'(MAX_TRIES));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         en_q       <= '0;
         dout_q     <= '0;
         pass_q     <= RST_PASS;
         fail_cnt_q <= '0;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         dout_q     <= dout_d;
         pass_q     <= pass_d;
         fail_cnt_q <= fail_cnt_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // Dropping rqst wins over a simultaneous confirm edge; TRAP ignores rqst entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rqst) state_d = ACTIVE;
         ACTIVE: begin
            if (!rqst)                      state_d = IDLE;
            else if (cedge && code_ok)      state_d = GRANT;
            else if (cedge && !budget_left) state_d = TRAP;
         end
         GRANT: begin
            if (!rqst)      state_d = IDLE;
            else if (cedge) state_d = SAVE;
         end
         SAVE:    if (!rqst) state_d = IDLE;
         TRAP:    if (lock_cnt_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      en_d       = en_q;
      dout_d     = dout_q;
      pass_d     = pass_q;
      fail_cnt_d = fail_cnt_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         IDLE:    if (rqst) en_d = '0;
         ACTIVE: begin
            if (!rqst) begin
               en_d = '0;
            end else if (cedge) begin
               if (code_ok) begin
                  fail_cnt_d = '0;
               end else if (budget_left) begin
                  fail_cnt_d = fail_inc[TW-1:0];
               end else begin
                  fail_cnt_d = TW'(MAX_TRIES);
                  lock_cnt_d = LW'(LOCK_CYCLES - 1);
               end
            end
         end
         GRANT:   if (!rqst) en_d = '0;
         SAVE: begin
            if (!rqst) begin
               en_d = '0;
            end else begin
               dout_d = pass_data;
               en_d   = EN_ONE << pass_data[SW-1:0];
               if (pass_wr) pass_d = pass_data;
            end
         end
         TRAP: begin
            if (lock_cnt_q == '0) fail_cnt_d = '0;
            else                  lock_cnt_d = lock_cnt_q - LW'(1);
         end
         default: en_d = '0;
      endcase
   end

   assign en         = en_q;
   assign dout       = dout_q;
   assign state      = state_q;
   assign tries_left = TW'(MAX_TRIES) - fail_cnt_q;
   assign locked     = (state_q == TRAP);

endmodule

// File: tb/tb_pass_lock_fsm.sv
// Directed self-checking bench for pass_lock_fsm at default parameters.
// Expected values are hand-derived from the controller's behaviour.
module tb_pass_lock_fsm;
   import pass_lock_pkg::*;

   logic       clk;
   logic       rst;
   logic       rqst;
   logic       confirm;
   logic [3:0] pass_data;
   logic       pass_wr;
   logic [1:0] en;
   logic [3:0] dout;
   logic [2:0] state;
   logic [1:0] tries_left;
   logic       locked;

   int checks   = 0;
   int failures = 0;

   pass_lock_fsm dut (
      .clk        (clk),
      .rst        (rst),
      .rqst       (rqst),
      .confirm    (confirm),
      .pass_data  (pass_data),
      .pass_wr    (pass_wr),
      .en         (en),
      .dout       (dout),
      .state      (state),
      .tries_left (tries_left),
      .locked     (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic r, input logic c,
                                 input logic [3:0] d, input logic w);
      rqst      = r;
      confirm   = c;
      pass_data = d;
      pass_wr   = w;
      tick();
   endtask

   task automatic submit(input logic [3:0] code);
      apply_stimulus(1'b1, 1'b1, code, 1'b0);
      apply_stimulus(1'b1, 1'b0, code, 1'b0);
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b0; rqst = 1'b0; confirm = 1'b0; pass_data = 4'h0; pass_wr = 1'b0;
      tick(); tick();
      check_output("rst_state",  32'(state),      32'(IDLE));
      check_output("rst_en",     32'(en),         32'h0);
      check_output("rst_dout",   32'(dout),       32'h0);
      check_output("rst_tries",  32'(tries_left), 32'd3);
      check_output("rst_locked", 32'(locked),     32'd0);
      rst = 1'b1;

      // Grant with the reset password, then steer channels in SAVE
      apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
      check_output("idle_to_active", 32'(state), 32'(ACTIVE));
      apply_stimulus(1'b1, 1'b1, 4'hF, 1'b0);
      check_output("grant", 32'(state), 32'(GRANT));
      apply_stimulus(1'b1, 1'b0, 4'hF, 1'b0);
      apply_stimulus(1'b1, 1'b1, 4'hF, 1'b0);
      check_output("save", 32'(state), 32'(SAVE));
      apply_stimulus(1'b1, 1'b0, 4'h6, 1'b0);
      check_output("save_dout6", 32'(dout), 32'h6);
      check_output("save_en6",   32'(en),   32'h1);
      apply_stimulus(1'b1, 1'b0, 4'h3, 1'b0);
      check_output("save_dout3", 32'(dout), 32'h3);
      check_output("save_en3",   32'(en),   32'h2);
      apply_stimulus(1'b0, 1'b0, 4'h3, 1'b0);
      check_output("save_exit_state", 32'(state), 32'(IDLE));
      check_output("save_exit_en",    32'(en),    32'h0);
      check_output("save_exit_dout",  32'(dout),  32'h3);

      // Wrong codes with a held confirm counting once, leading to TRAP
      apply_stimulus(1'b1, 1'b0, 4'h2, 1'b0);
      check_output("tries3", 32'(tries_left), 32'd3);
      apply_stimulus(1'b1, 1'b1, 4'h2, 1'b0);
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 4'h2, 1'b0);
      check_output("held_confirm_tries2", 32'(tries_left), 32'd2);
      check_output("held_confirm_state",  32'(state),      32'(ACTIVE));
      apply_stimulus(1'b1, 1'b0, 4'h2, 1'b0);
      apply_stimulus(1'b1, 1'b1, 4'h2, 1'b0);
      check_output("tries1", 32'(tries_left), 32'd1);
      apply_stimulus(1'b1, 1'b0, 4'h2, 1'b0);
      apply_stimulus(1'b1, 1'b1, 4'h2, 1'b0);
      check_output("trap_state",  32'(state),      32'(TRAP));
      check_output("trap_locked", 32'(locked),     32'd1);
      check_output("trap_tries",  32'(tries_left), 32'd0);
      for (int i = 0; i < 15; i++) begin
         apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
         check_output($sformatf("trap_dwell%0d", i), 32'(state), 32'(TRAP));
      end
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
      check_output("trap_expire_state",  32'(state),      32'(IDLE));
      check_output("trap_expire_tries",  32'(tries_left), 32'd3);
      check_output("trap_expire_locked", 32'(locked),     32'd0);

      // Dropping rqst does not refill the retry budget
      apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
      submit(4'h2);
      submit(4'h2);
      apply_stimulus(1'b0, 1'b0, 4'h2, 1'b0);
      check_output("abort_state", 32'(state),      32'(IDLE));
      check_output("abort_tries", 32'(tries_left), 32'd1);
      apply_stimulus(1'b1, 1'b0, 4'h2, 1'b0);
      check_output("rerqst_tries", 32'(tries_left), 32'd1);
      apply_stimulus(1'b1, 1'b1, 4'h2, 1'b0);
      check_output("rerqst_trap", 32'(state), 32'(TRAP));
      for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
      check_output("rerqst_trap_expire", 32'(state), 32'(IDLE));

      // Reprogram the password in SAVE
      apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
      submit(4'hF);
      apply_stimulus(1'b1, 1'b1, 4'hF, 1'b0);
      apply_stimulus(1'b1, 1'b0, 4'h9, 1'b1);
      check_output("prog_dout", 32'(dout), 32'h9);
      check_output("prog_en",   32'(en),   32'h2);
      apply_stimulus(1'b0, 1'b0, 4'h9, 1'b0);
      apply_stimulus(1'b1, 1'b0, 4'h9, 1'b0);
      submit(4'hF);
      check_output("old_pass_state", 32'(state),      32'(ACTIVE));
      check_output("old_pass_tries", 32'(tries_left), 32'd2);
      submit(4'h9);
      check_output("new_pass_state", 32'(state),      32'(GRANT));
      check_output("new_pass_tries", 32'(tries_left), 32'd3);

      // Asynchronous reset in SAVE after a reprogram
      apply_stimulus(1'b1, 1'b1, 4'h9, 1'b0);
      apply_stimulus(1'b1, 1'b0, 4'h5, 1'b0);
      check_output("save_pre_rst_en", 32'(en), 32'h2);
      rst = 1'b0;
      #1;
      check_output("rst_save_state", 32'(state), 32'(IDLE));
      check_output("rst_save_en",    32'(en),    32'h0);
      check_output("rst_save_dout",  32'(dout),  32'h0);
      tick();
      rst = 1'b1;
      apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
      submit(4'hF);
      check_output("rst_save_default_pass", 32'(state), 32'(GRANT));

      // Asynchronous reset in TRAP
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
      submit(4'h2);
      submit(4'h2);
      apply_stimulus(1'b1, 1'b1, 4'h2, 1'b0);
      apply_stimulus(1'b1, 1'b0, 4'h2, 1'b0);
      apply_stimulus(1'b1, 1'b0, 4'h2, 1'b0);
      check_output("pre_rst_trap", 32'(state), 32'(TRAP));
      rst = 1'b0;
      #1;
      check_output("rst_trap_state",  32'(state),      32'(IDLE));
      check_output("rst_trap_locked", 32'(locked),     32'd0);
      check_output("rst_trap_tries",  32'(tries_left), 32'd3);
      tick();
      rst = 1'b1;
      apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
      submit(4'hF);
      check_output("rst_trap_grant", 32'(state), 32'(GRANT));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
